// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   DATA_WIDTH_DEF : default width of a received word.
//   ptr_width()    : pointer width for a FIFO of the given depth. One extra
//                    bit beyond the address lets the pointers tell full from empty.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: Depth x DataWidth register array used as FIFO storage.
// Writes are synchronous. Reads are asynchronous, so the head word can fall
// through to the output without an extra cycle of latency.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_WIDTH_DEF,
    parameter int unsigned Depth     = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(Depth)-1:0]   waddr_i,
    input  logic [DataWidth-1:0]       wdata_i,
    input  logic [$clog2(Depth)-1:0]   raddr_i,
    output logic [DataWidth-1:0]       rdata_o
);

    // Storage is deliberately left without a reset. The pointers alone decide
    // which entries are valid.
    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO placed behind a UART receiver.
//   clk_i, rst_ni   : clock and asynchronous active-low reset
//   wr_tick_i       : one-cycle write strobe from the receiver's done tick
//   wr_data_i       : received word, sampled only when wr_tick_i=1
//   rd_ready_i      : consumer accepts the head word
//   rd_valid_o      : head word is present on rd_data_o
//   rd_data_o       : head word (don't-care when rd_valid_o=0)
//   level_o         : number of stored words, 0..Depth
//   empty_o/full_o  : level==0 / level==Depth
//   almost_full_o   : level >= AlmostFullLevel
//   overrun_o       : sticky flag, set when a write was dropped
//   overrun_clr_i   : synchronous clear of overrun_o (a drop in the same cycle wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth       = DATA_WIDTH_DEF,
    parameter int unsigned Depth           = 16,
    parameter int unsigned AlmostFullLevel = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_tick_i,
    input  logic [DataWidth-1:0]        wr_data_i,
    input  logic                        rd_ready_i,
    output logic                        rd_valid_o,
    output logic [DataWidth-1:0]        rd_data_o,
    output logic [$clog2(Depth):0]      level_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        almost_full_o,
    output logic                        overrun_o,
    input  logic                        overrun_clr_i
);

    localparam int unsigned PtrW  = ptr_width(Depth);
    localparam int unsigned AddrW = PtrW - 1;

    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW-1:0] AfLevel = PtrW'(AlmostFullLevel);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;

    logic            empty, full;
    logic [PtrW-1:0] level;
    logic            push, pop, drop;

    // All status outputs depend only on the pointer registers. No input
    // reaches them combinationally.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    // The pointers wrap modulo 2*Depth, so their difference is already
    // in the range 0..Depth.
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop only happens when data is visible. On an empty FIFO a
    // simultaneous write is stored and is not consumed in the same cycle.
    assign pop  = !empty && rd_ready_i;
    // When the FIFO is full, a write can still be accepted if the head leaves
    // in the same cycle. The slot being overwritten is the one being popped,
    // and its old value is read through the asynchronous port before the edge.
    assign push = wr_tick_i && (!full || pop);
    assign drop = wr_tick_i && !push;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AddrW-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[AddrW-1:0]),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o    = !empty;
    assign level_o       = level;
    assign empty_o       = empty;
    assign full_o        = full;
    assign almost_full_o = (level >= AfLevel);
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       wr_tick_i;
    logic [7:0] wr_data_i;
    logic       rd_ready_i;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic [4:0] level_o;
    logic       empty_o;
    logic       full_o;
    logic       almost_full_o;
    logic       overrun_o;
    logic       overrun_clr_i;

    uart_rx_fifo #(.DataWidth(8), .Depth(DEPTH), .AlmostFullLevel(AFL)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_tick_i     (wr_tick_i),
        .wr_data_i     (wr_data_i),
        .rd_ready_i    (rd_ready_i),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .level_o       (level_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         rdy;
        bit         clr;
        int         lvl;
        bit         ovr;
        string      nm;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Compares the status outputs with the scoreboard occupancy. When data is
    // present, it also checks that the head word is the oldest one still queued.
    task automatic chk_state(input string nm);
        int n;
        n = sb.size();
        chk({nm, ".empty"}, int'(empty_o),       int'(n == 0));
        chk({nm, ".full"},  int'(full_o),        int'(n == DEPTH));
        chk({nm, ".afull"}, int'(almost_full_o), int'(n >= AFL));
        chk({nm, ".valid"}, int'(rd_valid_o),    int'(n != 0));
        if (n != 0) chk({nm, ".head"}, int'(rd_data_o), int'(sb[0]));
    endtask

    function automatic void add(input bit wr, input logic [7:0] d, input bit rdy,
                                input bit clr, input int lvl, input bit ovr,
                                input string nm);
        vec_t v;
        v.wr = wr; v.d = d; v.rdy = rdy; v.clr = clr; v.lvl = lvl; v.ovr = ovr; v.nm = nm;
        vt.push_back(v);
    endfunction

    // Call this task at posedge+1. It drives one cycle of stimulus and compares
    // any popped word before the edge. After the edge it checks the level and
    // overrun flag against the expected values and the flags against the
    // scoreboard.
    task automatic step(input vec_t v);
        bit pop, push;
        wr_tick_i = v.wr; wr_data_i = v.d; rd_ready_i = v.rdy; overrun_clr_i = v.clr;
        @(negedge clk_i);
        pop  = (sb.size() > 0) && v.rdy;
        push = v.wr && ((sb.size() < DEPTH) || pop);
        if (pop) chk({v.nm, ".pop_data"}, int'(rd_data_o), int'(sb[0]));
        @(posedge clk_i);
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(v.d);
        #1;
        chk({v.nm, ".level"},   int'(level_o),   v.lvl);
        chk({v.nm, ".overrun"}, int'(overrun_o), int'(v.ovr));
        chk_state(v.nm);
    endtask

    initial begin
        vec_t v;
        rst_ni = 1'b1; wr_tick_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0; overrun_clr_i = 1'b0;

        // Reset asserted before any clock edge: the outputs must respond asynchronously.
        #3 rst_ni = 1'b0;
        #1;
        chk("rst.level", int'(level_o), 0);
        chk("rst.overrun", int'(overrun_o), 0);
        chk_state("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single word, one-cycle latency, then a pop.
        add(1, 8'hA5, 0, 0, 1, 0, "single_wr");
        add(0, 8'h00, 0, 0, 1, 0, "single_hold");
        add(0, 8'h00, 1, 0, 0, 0, "single_pop");
        // Fill to full. almost_full is checked at every level.
        for (int i = 0; i < DEPTH; i++) add(1, 8'(i), 0, 0, i + 1, 0, "fill");
        // A drop coinciding with a clear: the set wins.
        add(1, 8'hFF, 0, 1, DEPTH, 1, "drop_clr");
        add(0, 8'h00, 0, 1, DEPTH, 0, "clr_alone");
        add(1, 8'hFF, 0, 0, DEPTH, 1, "drop");
        add(0, 8'h00, 0, 1, DEPTH, 0, "clr2");
        // Push and pop together while full.
        add(1, 8'h55, 1, 0, DEPTH, 0, "full_pushpop");
        for (int i = 0; i < DEPTH; i++) add(0, 8'h00, 1, 0, DEPTH - 1 - i, 0, "drain");
        // Streaming through the FIFO: wraps the pointers and keeps the level at 1 or below.
        for (int i = 0; i < 40; i++) add(1, 8'(8'h80 + i), 1, 0, 1, 0, "stream");
        add(0, 8'h00, 1, 0, 0, 0, "stream_end");
        // Write on empty with ready high: the word is stored, not popped.
        add(1, 8'h77, 1, 0, 1, 0, "wr_empty_rdy");
        add(0, 8'h00, 1, 0, 0, 0, "wr_empty_pop");

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // Reset pulse in the middle of operation at level 7.
        for (int i = 0; i < 7; i++) begin
            v.wr = 1; v.d = 8'(8'h10 + i); v.rdy = 0; v.clr = 0; v.lvl = i + 1; v.ovr = 0; v.nm = "pre_rst";
            step(v);
        end
        wr_tick_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        sb.delete();
        chk("midrst.level", int'(level_o), 0);
        chk("midrst.overrun", int'(overrun_o), 0);
        chk_state("midrst");
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        v.wr = 1; v.d = 8'h3C; v.rdy = 0; v.clr = 0; v.lvl = 1; v.ovr = 0; v.nm = "post_rst_wr";
        step(v);
        chk("post_rst.head", int'(rd_data_o), 32'h3C);
        v.wr = 0; v.d = 8'h00; v.rdy = 1; v.lvl = 0; v.nm = "post_rst_pop";
        step(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
